lock_sequencer: RTL and testbench



---
 rtl/lock_pkg.sv | 27 ++
 rtl/lock_timer.sv | 38 +++
 rtl/lock_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_lock_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// lock_pkg: shared types and constants for the passcode lock controller.
//   state_t   - controller states (PROG is only reachable with LOCK_CODE_PROG_EN)
//   KEY_ESC   - abort key, KEY_HASH - code programming key
//   TIMER_W   - width of the shared interval timer
//   code_byte - extracts passcode byte idx (byte 0 is the most significant used byte)
package lock_pkg;

    localparam int         TIMER_W  = 32;
    localparam logic [7:0] KEY_ESC  = 8'h1B;
    localparam logic [7:0] KEY_HASH = 8'h23;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        OPEN,
        LOCK,
        PROG
    } state_t;

    function automatic logic [7:0] code_byte(input logic [63:0] code, input int len, input int idx);
        logic [63:0] w_sh;
        w_sh = code >> (8 * (len - 1 - idx));
        return w_sh[7:0];
    endfunction

endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter that stops at zero.
//   clk, reset   - clock, synchronous active-high reset (count -> 0)
//   i_load       - load i_load_val this cycle (has priority over i_en)
//   i_load_val   - value to load
//   i_en         - decrement by one when the count is non-zero
//   o_expired    - count == 0
//   o_count      - current count (only with LOCK_CODE_PROG_EN, used to freeze/restore)
module lock_timer
    import lock_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    input  logic               i_en,
`ifdef LOCK_CODE_PROG_EN
    output logic [TIMER_W-1:0] o_count,
`endif
    output logic               o_expired
);

    logic [TIMER_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (i_en && r_count != '0)
            r_count <= r_count - 32'd1;
    end

    assign o_expired = (r_count == '0);
`ifdef LOCK_CODE_PROG_EN
    assign o_count = r_count;
`endif

endmodule

// File: rtl/lock_sequencer.sv
// lock_sequencer: digital-lock passcode controller fed by a UART byte stream.
//   clk, reset      - clock, synchronous active-high reset
//   rx_data/valid   - received byte and its one-cycle strobe
//   unlocked        - lock open (held for UNLOCK_CYCLES)
//   lockout         - too many failures (held for LOCKOUT_CYCLES)
//   entry_active    - passcode bytes being collected
//   attempts_left   - tries remaining before lockout
//   fail_pulse      - one cycle per failed attempt, coincident with the decremented attempts_left
// Optional: define LOCK_CODE_PROG_EN to allow '#' while open to reprogram the passcode.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int                 CODE_LEN       = 4,
    parameter logic [63:0]        CODE           = 64'h31323334,
    parameter int                 MAX_TRIES      = 3,
    parameter logic [7:0]         CLEAR_KEY      = KEY_ESC,
    parameter logic [TIMER_W-1:0] UNLOCK_CYCLES  = 32'd500_000_000,
    parameter logic [TIMER_W-1:0] LOCKOUT_CYCLES = 32'd3_000_000_000,
    parameter logic [TIMER_W-1:0] TIMEOUT_CYCLES = 32'd1_000_000_000
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       unlocked,
    output logic       lockout,
    output logic       entry_active,
    output logic [3:0] attempts_left,
    output logic       fail_pulse
);

    // The timer transitions the FSM on the cycle it reads zero, so loading N-1
    // gives an interval of exactly N cycles.
    localparam logic [TIMER_W-1:0] UNLOCK_LD  = (UNLOCK_CYCLES  == '0) ? '0 : UNLOCK_CYCLES  - 32'd1;
    localparam logic [TIMER_W-1:0] LOCKOUT_LD = (LOCKOUT_CYCLES == '0) ? '0 : LOCKOUT_CYCLES - 32'd1;
    localparam logic [TIMER_W-1:0] TIMEOUT_LD = (TIMEOUT_CYCLES == '0) ? '0 : TIMEOUT_CYCLES - 32'd1;
    localparam logic [3:0]         TRIES_INIT = 4'(MAX_TRIES);
    localparam logic [3:0]         LAST_IDX   = 4'(CODE_LEN - 1);

    state_t             r_state;
    logic [3:0]         r_index;
    logic               r_mismatch;
    logic [3:0]         r_attempts;
    logic               r_unlocked, r_lockout, r_entry_active, r_fail_pulse;
    logic [63:0]        w_code;
    logic               w_byte_bad;
    logic               w_load, w_en, w_expired;
    logic [TIMER_W-1:0] w_load_val;

`ifdef LOCK_CODE_PROG_EN
    logic [63:0]        r_code;
    logic [63:0]        r_prog_buf;
    logic [3:0]         r_prog_idx;
    logic [TIMER_W-1:0] r_hold;      // unlock time remaining when PROG was entered
    logic [TIMER_W-1:0] w_count;
    assign w_code = r_code;
`else
    assign w_code = CODE;
`endif

    // r_index is 0 in IDLE, so the same compare serves the first byte.
    assign w_byte_bad = (rx_data != code_byte(w_code, CODE_LEN, int'(r_index)));

    lock_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (w_en),
`ifdef LOCK_CODE_PROG_EN
        .o_count    (w_count),
`endif
        .o_expired  (w_expired)
    );

    // Timer control: one interval at a time, chosen by the current state.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        w_en       = 1'b0;
        case (r_state)
            IDLE:  if (rx_valid && rx_data != CLEAR_KEY) begin
                       w_load = 1'b1; w_load_val = TIMEOUT_LD;
                   end
            ENTRY: if (rx_valid) begin
                       if (rx_data != CLEAR_KEY) begin
                           w_load = 1'b1; w_load_val = TIMEOUT_LD;
                       end
                   end else w_en = 1'b1;
            CHECK: if (!r_mismatch) begin
                       w_load = 1'b1; w_load_val = UNLOCK_LD;
                   end else if (r_attempts <= 4'd1) begin
                       w_load = 1'b1; w_load_val = LOCKOUT_LD;
                   end
`ifdef LOCK_CODE_PROG_EN
            OPEN:  if (rx_valid && rx_data == KEY_HASH) begin
                       w_load = 1'b1; w_load_val = TIMEOUT_LD;
                   end else w_en = 1'b1;
            PROG:  if (rx_valid) begin
                       w_load = 1'b1;
                       if (rx_data == CLEAR_KEY)       w_load_val = r_hold;
                       else if (r_prog_idx == LAST_IDX) w_load_val = UNLOCK_LD;
                       else                             w_load_val = TIMEOUT_LD;
                   end else if (w_expired) begin
                       w_load = 1'b1; w_load_val = r_hold;
                   end else w_en = 1'b1;
`else
            OPEN:  w_en = 1'b1;
`endif
            LOCK:  w_en = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_index        <= '0;
            r_mismatch     <= 1'b0;
            r_attempts     <= TRIES_INIT;
            r_unlocked     <= 1'b0;
            r_lockout      <= 1'b0;
            r_entry_active <= 1'b0;
            r_fail_pulse   <= 1'b0;
`ifdef LOCK_CODE_PROG_EN
            r_code         <= CODE;
            r_prog_buf     <= '0;
            r_prog_idx     <= '0;
            r_hold         <= '0;
`endif
        end else begin
            r_fail_pulse <= 1'b0;
            case (r_state)
                IDLE: if (rx_valid && rx_data != CLEAR_KEY) begin
                    r_index    <= 4'd1;
                    r_mismatch <= w_byte_bad;
                    if (CODE_LEN == 1) begin
                        r_state <= CHECK;
                    end else begin
                        r_state        <= ENTRY;
                        r_entry_active <= 1'b1;
                    end
                end
                ENTRY: if (rx_valid) begin
                    if (rx_data == CLEAR_KEY) begin
                        r_index        <= '0;
                        r_mismatch     <= 1'b0;
                        r_state        <= IDLE;
                        r_entry_active <= 1'b0;
                    end else begin
                        r_mismatch <= r_mismatch | w_byte_bad;
                        r_index    <= r_index + 4'd1;
                        if (r_index == LAST_IDX) begin
                            r_state        <= CHECK;
                            r_entry_active <= 1'b0;
                        end
                    end
                end else if (w_expired) begin
                    r_index        <= '0;
                    r_mismatch     <= 1'b0;
                    r_state        <= IDLE;
                    r_entry_active <= 1'b0;
                end
                CHECK: begin
                    r_index    <= '0;
                    r_mismatch <= 1'b0;
                    if (!r_mismatch) begin
                        r_state    <= OPEN;
                        r_unlocked <= 1'b1;
                        r_attempts <= TRIES_INIT;
                    end else begin
                        r_fail_pulse <= 1'b1;
                        r_attempts   <= (r_attempts == '0) ? '0 : r_attempts - 4'd1;
                        if (r_attempts <= 4'd1) begin
                            r_state   <= LOCK;
                            r_lockout <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                OPEN: begin
`ifdef LOCK_CODE_PROG_EN
                    if (rx_valid && rx_data == KEY_HASH) begin
                        r_state    <= PROG;
                        r_prog_idx <= '0;
                        r_hold     <= w_count;
                    end else
`endif
                    if (w_expired) begin
                        r_state    <= IDLE;
                        r_unlocked <= 1'b0;
                    end
                end
                LOCK: if (w_expired) begin
                    r_state    <= IDLE;
                    r_lockout  <= 1'b0;
                    r_attempts <= TRIES_INIT;
                end
`ifdef LOCK_CODE_PROG_EN
                PROG: if (rx_valid) begin
                    if (rx_data == CLEAR_KEY) begin
                        r_state <= OPEN;
                    end else begin
                        r_prog_buf <= {r_prog_buf[55:0], rx_data};
                        r_prog_idx <= r_prog_idx + 4'd1;
                        if (r_prog_idx == LAST_IDX) begin
                            r_code  <= {r_prog_buf[55:0], rx_data};
                            r_state <= OPEN;
                        end
                    end
                end else if (w_expired) begin
                    r_state <= OPEN;
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign unlocked      = r_unlocked;
    assign lockout       = r_lockout;
    assign entry_active  = r_entry_active;
    assign attempts_left = r_attempts;
    assign fail_pulse    = r_fail_pulse;

endmodule

// File: tb/tb_lock_sequencer.sv
// tb_lock_sequencer: directed scenarios plus randomized attempts, checked every
// cycle against a reference model that works with entered-byte queues and
// absolute deadline cycles.
module tb_lock_sequencer;

    localparam int CL  = 4;
    localparam int MT  = 3;
    localparam int UNL = 20;
    localparam int LKO = 50;
    localparam int TMO = 100;
    localparam logic [7:0] ESC = 8'h1B;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       unlocked, lockout, entry_active, fail_pulse;
    logic [3:0] attempts_left;

    lock_sequencer #(
        .CODE_LEN(CL), .CODE(64'h31323334), .MAX_TRIES(MT), .CLEAR_KEY(ESC),
        .UNLOCK_CYCLES(32'd20), .LOCKOUT_CYCLES(32'd50), .TIMEOUT_CYCLES(32'd100)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .unlocked(unlocked), .lockout(lockout), .entry_active(entry_active),
        .attempts_left(attempts_left), .fail_pulse(fail_pulse)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model
    typedef enum int { M_IDLE, M_COLLECT, M_CHECK, M_OPEN, M_LOCK } mode_t;
    mode_t      m_mode = M_IDLE;
    logic [7:0] m_q[$];
    logic [7:0] code_q[CL] = '{8'h31, 8'h32, 8'h33, 8'h34};
    int         n = 0;
    int         m_last = 0;
    int         m_end = 0;
    int         m_tries = MT;
    logic       m_fail = 1'b0;
    int         fail_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d, input logic rst);
        bit ok;
        n++;
        m_fail = 1'b0;
        if (rst) begin
            m_mode = M_IDLE; m_tries = MT; m_q.delete();
            return;
        end
        case (m_mode)
            M_IDLE: if (v && d != ESC) begin
                m_q.delete(); m_q.push_back(d); m_last = n; m_mode = M_COLLECT;
            end
            M_COLLECT: if (v) begin
                if (d == ESC) begin
                    m_q.delete(); m_mode = M_IDLE;
                end else begin
                    m_q.push_back(d); m_last = n;
                    if (m_q.size() == CL) m_mode = M_CHECK;
                end
            end else if (n - m_last >= TMO) begin
                m_q.delete(); m_mode = M_IDLE;
            end
            M_CHECK: begin
                ok = 1'b1;
                for (int i = 0; i < CL; i++) if (m_q[i] != code_q[i]) ok = 1'b0;
                m_q.delete();
                if (ok) begin
                    m_mode = M_OPEN; m_end = n + UNL; m_tries = MT;
                end else begin
                    m_fail = 1'b1; m_tries--;
                    if (m_tries == 0) begin m_mode = M_LOCK; m_end = n + LKO; end
                    else m_mode = M_IDLE;
                end
            end
            M_OPEN: if (n == m_end) m_mode = M_IDLE;
            M_LOCK: if (n == m_end) begin m_mode = M_IDLE; m_tries = MT; end
            default: ;
        endcase
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic rst);
        rx_valid = v; rx_data = d; reset = rst;
        @(posedge clk); #1;
        model_edge(v, d, rst);
        rx_valid = 1'b0; reset = 1'b0;
        if (fail_pulse === 1'b1) fail_seen++;
        chk("unlocked",      32'(unlocked),      32'(m_mode == M_OPEN));
        chk("lockout",       32'(lockout),       32'(m_mode == M_LOCK));
        chk("entry_active",  32'(entry_active),  32'(m_mode == M_COLLECT));
        chk("attempts_left", 32'(attempts_left), 32'(m_tries));
        chk("fail_pulse",    32'(fail_pulse),    32'(m_fail));
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] e);
        step(1'b1, a, 1'b0); step(1'b1, b, 1'b0); step(1'b1, c, 1'b0); step(1'b1, e, 1'b0);
    endtask

    initial begin
        int cnt, first, f0, kind, gap;
        logic [7:0] b;

        // Reset state
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("rst_attempts", 32'(attempts_left), 32'd3);
        chk("rst_outputs", {28'd0, unlocked, lockout, entry_active, fail_pulse}, 32'd0);

        // Correct code: strobe in cycle c, CHECK in c+1, unlocked from c+2,
        // i.e. visible after the first idle edge; held exactly UNL cycles.
        send4(8'h31, 8'h32, 8'h33, 8'h34);
        chk("lat_check_cycle", 32'(unlocked), 32'd0);
        cnt = 0; first = -1;
        for (int i = 1; i <= 30; i++) begin
            idle(1);
            if (unlocked === 1'b1) begin cnt++; if (first < 0) first = i; end
        end
        chk("open_rise", 32'(first), 32'd1);
        chk("open_len", 32'(cnt), 32'(UNL));
        chk("open_attempts", 32'(attempts_left), 32'd3);

        // One wrong code
        f0 = fail_seen;
        send4(8'h31, 8'h32, 8'h39, 8'h34);
        idle(3);
        chk("wrong_fail_cnt", 32'(fail_seen - f0), 32'd1);
        chk("wrong_attempts", 32'(attempts_left), 32'd2);

        // Three wrong codes -> lockout; bytes during lockout ignored
        step(1'b0, 8'h00, 1'b1);
        send4(8'h35, 8'h35, 8'h35, 8'h35); idle(2);
        chk("tries_a", 32'(attempts_left), 32'd2);
        send4(8'h31, 8'h32, 8'h33, 8'h33); idle(2);
        chk("tries_b", 32'(attempts_left), 32'd1);
        send4(8'h30, 8'h30, 8'h30, 8'h30);
        cnt = 0;
        for (int i = 1; i <= 60; i++) begin
            if (i >= 3 && i <= 45 && (i % 3 == 0)) step(1'b1, code_q[(i / 3) % CL], 1'b0);
            else idle(1);
            if (lockout === 1'b1) cnt++;
        end
        chk("lockout_len", 32'(cnt), 32'(LKO));
        chk("lockout_tries", 32'(attempts_left), 32'd3);
        send4(8'h31, 8'h32, 8'h33, 8'h34); idle(2);
        chk("open_after_lock", 32'(unlocked), 32'd1);
        idle(25);

        // ESC aborts without consuming an attempt
        f0 = fail_seen;
        step(1'b1, 8'h31, 1'b0); step(1'b1, 8'h32, 1'b0); step(1'b1, ESC, 1'b0);
        idle(2);
        chk("esc_entry", 32'(entry_active), 32'd0);
        send4(8'h31, 8'h32, 8'h33, 8'h34); idle(2);
        chk("esc_nofail", 32'(fail_seen - f0), 32'd0);
        chk("esc_then_open", 32'(unlocked), 32'd1);
        idle(25);

        // Inter-key timeout, then a fresh 4-byte entry "3412"
        f0 = fail_seen;
        step(1'b1, 8'h31, 1'b0); step(1'b1, 8'h32, 1'b0);
        idle(TMO);
        chk("timeout_entry", 32'(entry_active), 32'd0);
        chk("timeout_nofail", 32'(fail_seen - f0), 32'd0);
        send4(8'h33, 8'h34, 8'h31, 8'h32); idle(2);
        chk("fresh_fail", 32'(fail_seen - f0), 32'd1);
        chk("fresh_attempts", 32'(attempts_left), 32'd2);

        // Reset during OPEN and during lockout
        send4(8'h31, 8'h32, 8'h33, 8'h34); idle(5);
        step(1'b0, 8'h00, 1'b1);
        chk("rst_open", {24'd0, unlocked, lockout, entry_active, fail_pulse, attempts_left}, 32'h3);
        for (int k = 0; k < MT; k++) begin send4(8'h39, 8'h39, 8'h39, 8'h39); idle(1); end
        idle(5);
        step(1'b0, 8'h00, 1'b1);
        chk("rst_lock", {24'd0, unlocked, lockout, entry_active, fail_pulse, attempts_left}, 32'h3);

        // Randomized attempts checked against the model every cycle
        for (int t = 0; t < 60; t++) begin
            kind = int'($urandom_range(0, 4));
            for (int i = 0; i < CL; i++) begin
                case (kind)
                    0: b = code_q[i];
                    1: b = 8'h30 + 8'($urandom_range(0, 9));
                    default: b = (i < 2) ? code_q[i] : 8'h30 + 8'($urandom_range(0, 9));
                endcase
                if (kind == 2 && i == 2) b = ESC;
                step(1'b1, b, 1'b0);
                if (kind == 3 && i == 1) idle(int'($urandom_range(TMO - 3, TMO + 3)));
                else idle(int'($urandom_range(0, 3)));
            end
            gap = int'($urandom_range(0, 60));
            idle(gap);
            if ($urandom_range(0, 19) == 0) step(1'b0, 8'h00, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
